morse_encoder: RTL
==================

# morse_encoder

Transmit-side keyer for the Morse path: accepts 8-bit ASCII characters over a valid/ready handshake and drives a single key line with ITU Morse timing (dot, dash and gaps in integer units). It sits directly upstream of the Morse decoder: `key_out` is wired to the decoder's serial `in`, and the decoder's `clk` and `reset` are shared. This makes loopback encode/decode benches possible.

## Interface
- `UNIT_CYCLES`, default 4: clock cycles per Morse unit; legal range 1..65535.
- `clk` in 1: rising-edge clock.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `char_in` in 8: ASCII character to send.
- `char_valid` in 1: `char_in` is valid.
- `char_ready` out 1: encoder can accept a character this cycle.
- `key_out` out 1: Morse key line; 1 = mark (tone), 0 = space.
- `busy` out 1: a character or word gap is in progress.
- `bad_char` out 1: one-cycle pulse when an unsupported character is dropped.

## Operation
- Handshake:
  - Transfer happens on a rising edge with `char_valid && char_ready`.
  - `char_ready` = 1 only in IDLE.
  - `char_in` is ignored at all other times; the source must hold it.
- Lookup, performed combinationally at accept and registered:
  - Lowercase a–z (0x61–0x7A) always folds to A–Z.
  - Registered fields: `len` (3 bits, 1..5) and `pat` (5 bits, element 0 = LSB, 1 = dash).
- Character classes:
  - A–Z: ITU code.
  - 0–9: ITU code, only with `MORSE_DIGITS_EN`.
  - 0x20 space: word gap.
  - Anything else: unsupported.
- States:
  - IDLE: `key_out`=0, `busy`=0, `char_ready`=1.
    - Letter/digit accept → MARK at element 0.
    - Space accept → WORD_GAP.
    - Unsupported accept → stays IDLE and pulses `bad_char`.
  - MARK: `key_out`=1 for 1 unit (dot) or 3 units (dash).
    - Last element → CHAR_GAP.
    - Otherwise → ELEM_GAP.
  - ELEM_GAP: `key_out`=0 for 1 unit, then element index +1 → MARK.
  - CHAR_GAP: `key_out`=0 for 3 units → IDLE.
  - WORD_GAP: `key_out`=0 for 4 units → IDLE. Together with the preceding CHAR_GAP this yields a 7-unit word space.
- Counters:
  - Unit counter: 16 bits, counts 0..UNIT_CYCLES−1; a unit tick fires at UNIT_CYCLES−1.
  - Unit multiplier counter: 2 bits (up to 4 units).
  - Element index: 3 bits.
  - No counter wraps in legal use.
- `busy` = 1 in MARK, ELEM_GAP, CHAR_GAP and WORD_GAP.
- All outputs are registered.

## Timing
- Reset values: `key_out`=0, `busy`=0, `bad_char`=0, `char_ready`=1, state IDLE, all counters 0.
- Cycle numbering: accept occurs in cycle 0, and the first mark cycle is cycle 1 (latency 1).
- Element durations: dot = U cycles, dash = 3U, element gap = U, character gap = 3U, word gap = 4U, where U = UNIT_CYCLES.
- IDLE dwell: after CHAR_GAP or WORD_GAP the encoder returns to IDLE. Back-to-back characters therefore have 3U+1 low cycles between them (the +1 is the IDLE accept cycle).
- Unsupported character:
  - `bad_char`=1 in cycle 1 only.
  - `char_ready` stays 1.
  - `key_out` stays 0.
- `char_valid` held high while busy has no effect. The held character is accepted in the first IDLE cycle.
- Reset mid-operation:
  - Next edge forces all reset values.
  - `key_out` drops immediately even mid-mark.
  - The partial character is discarded.
- Reset coincident with `char_valid`: reset wins; nothing is accepted.

## Configuration
- `MORSE_DIGITS_EN` defined:
  - 0–9 are encoded, 5 elements each: '0' = -----, '1' = .----, through '5' = ....., through '9' = ----.
  - The encode table adds 10 entries.
- `MORSE_DIGITS_EN` undefined:
  - 0x30–0x39 are unsupported: dropped, with a `bad_char` pulse.
  - No digit table logic is synthesized.

## Test plan
All scenarios use UNIT_CYCLES=4 and accept in cycle 0.
- Reset asserted for 2 cycles mid-dash of 'O' → `key_out`=0 on the next edge; `char_ready`=1 and `busy`=0. A following 'E' then sends correctly.
- 'E' (0x45) → `key_out`=1 in cycles 1–4, 0 in cycles 5–16; `char_ready`=1 again in cycle 17.
- 'A' (0x41) → `key_out`=1 in cycles 1–4, 0 in 5–8, 1 in 9–20, 0 in 21–32; ready in cycle 33. 'a' (0x61) gives an identical waveform.
- Space (0x20) → `busy`=1 and `key_out`=0 in cycles 1–16; ready in cycle 17. '#' (0x23) → `bad_char`=1 in cycle 1 only; `char_ready` never drops.
- '5' (0x35):
  - With `MORSE_DIGITS_EN`: five 4-cycle marks at cycles 1, 9, 17, 25, 33; ready in cycle 49.
  - Without it: `bad_char` pulse in cycle 1 and no marks.
- Loopback: "SOS" streamed with `char_valid` held high into `morse_encoder` → decoder → decoder `out` sequence 0x53, 0x4F, 0x53. Handshake stalls are respected; no character is lost or duplicated.

Source files
------------

// File: rtl/morse_encoder_if.sv
// Character-in / key-out bundle for the Morse keyer.
// A character transfers on the rising edge where char_valid && char_ready; the source holds char_in until then.
interface morse_encoder_if;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic       key_out;
    logic       busy;
    logic       bad_char;
    logic [2:0] dbg_state;

    modport master (
        output char_in, char_valid,
        input  char_ready, key_out, busy, bad_char, dbg_state
    );

    modport slave (
        input  char_in, char_valid,
        output char_ready, key_out, busy, bad_char, dbg_state
    );
endinterface

// File: rtl/morse_encoder.sv
// ASCII to Morse keyer driving a single key line with ITU unit timing.
// Optional macro MORSE_DIGITS_EN adds the 0-9 encode table.
module morse_encoder #(
    parameter int unsigned UNIT_CYCLES = 4
) (
    input logic            clk,
    input logic            reset,
    morse_encoder_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MARK     = 3'd1,
        S_ELEM_GAP = 3'd2,
        S_CHAR_GAP = 3'd3,
        S_WORD_GAP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] unit_cnt_q, unit_cnt_d;
    logic [1:0]  mult_q, mult_d;
    logic [2:0]  elem_idx_q, elem_idx_d;
    logic [2:0]  len_q, len_d;
    logic [4:0]  pat_q, pat_d;
    logic        key_out_q, key_out_d;
    logic        busy_q, busy_d;
    logic        char_ready_q, char_ready_d;
    logic        bad_char_q, bad_char_d;

    logic [9:0]  lk;
    logic        tick;
    logic        done;
    logic [1:0]  dur_units;

    // Result packing: {is_symbol, is_space, len[2:0], pat[4:0]}; pat bit i is element i, 1 = dash.
    function automatic logic [9:0] lookup_char(input logic [7:0] ch);
        logic [7:0] c;
        logic [9:0] r;
        c = ch;
        if (ch >= 8'h61 && ch <= 8'h7A) c = ch - 8'h20;
        r = 10'd0;
        case (c)
            8'h20: r = {2'b01, 3'd0, 5'b00000};
            8'h41: r = {2'b10, 3'd2, 5'b00010};
            8'h42: r = {2'b10, 3'd4, 5'b00001};
            8'h43: r = {2'b10, 3'd4, 5'b00101};
            8'h44: r = {2'b10, 3'd3, 5'b00001};
            8'h45: r = {2'b10, 3'd1, 5'b00000};
            8'h46: r = {2'b10, 3'd4, 5'b00100};
            8'h47: r = {2'b10, 3'd3, 5'b00011};
            8'h48: r = {2'b10, 3'd4, 5'b00000};
            8'h49: r = {2'b10, 3'd2, 5'b00000};
            8'h4A: r = {2'b10, 3'd4, 5'b01110};
            8'h4B: r = {2'b10, 3'd3, 5'b00101};
            8'h4C: r = {2'b10, 3'd4, 5'b00010};
            8'h4D: r = {2'b10, 3'd2, 5'b00011};
            8'h4E: r = {2'b10, 3'd2, 5'b00001};
            8'h4F: r = {2'b10, 3'd3, 5'b00111};
            8'h50: r = {2'b10, 3'd4, 5'b00110};
            8'h51: r = {2'b10, 3'd4, 5'b01011};
            8'h52: r = {2'b10, 3'd3, 5'b00010};
            8'h53: r = {2'b10, 3'd3, 5'b00000};
            8'h54: r = {2'b10, 3'd1, 5'b00001};
            8'h55: r = {2'b10, 3'd3, 5'b00100};
            8'h56: r = {2'b10, 3'd4, 5'b01000};
            8'h57: r = {2'b10, 3'd3, 5'b00110};
            8'h58: r = {2'b10, 3'd4, 5'b01001};
            8'h59: r = {2'b10, 3'd4, 5'b01101};
            8'h5A: r = {2'b10, 3'd4, 5'b00011};
`ifdef MORSE_DIGITS_EN
            8'h30: r = {2'b10, 3'd5, 5'b11111};
            8'h31: r = {2'b10, 3'd5, 5'b11110};
            8'h32: r = {2'b10, 3'd5, 5'b11100};
            8'h33: r = {2'b10, 3'd5, 5'b11000};
            8'h34: r = {2'b10, 3'd5, 5'b10000};
            8'h35: r = {2'b10, 3'd5, 5'b00000};
            8'h36: r = {2'b10, 3'd5, 5'b00001};
            8'h37: r = {2'b10, 3'd5, 5'b00011};
            8'h38: r = {2'b10, 3'd5, 5'b00111};
            8'h39: r = {2'b10, 3'd5, 5'b01111};
`endif
            default: r = 10'd0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        unit_cnt_d = unit_cnt_q;
        mult_d     = mult_q;
        elem_idx_d = elem_idx_q;
        len_d      = len_q;
        pat_d      = pat_q;
        bad_char_d = 1'b0;
        lk         = lookup_char(bus.char_in);
        tick       = (unit_cnt_q == 16'(UNIT_CYCLES - 1));

        case (state_q)
            S_MARK:     dur_units = pat_q[elem_idx_q] ? 2'd2 : 2'd0;
            S_CHAR_GAP: dur_units = 2'd2;
            S_WORD_GAP: dur_units = 2'd3;
            default:    dur_units = 2'd0;
        endcase
        done = tick && (mult_q == dur_units);

        if (state_q == S_IDLE) begin
            unit_cnt_d = 16'd0;
            mult_d     = 2'd0;
            elem_idx_d = 3'd0;
            if (bus.char_valid) begin
                if (lk[9]) begin
                    state_d = S_MARK;
                    len_d   = lk[7:5];
                    pat_d   = lk[4:0];
                end else if (lk[8]) begin
                    state_d = S_WORD_GAP;
                end else begin
                    bad_char_d = 1'b1;
                end
            end
        end else if (done) begin
            unit_cnt_d = 16'd0;
            mult_d     = 2'd0;
            case (state_q)
                S_MARK:     state_d = (elem_idx_q == len_q - 3'd1) ? S_CHAR_GAP : S_ELEM_GAP;
                S_ELEM_GAP: begin
                    state_d    = S_MARK;
                    elem_idx_d = elem_idx_q + 3'd1;
                end
                default:    state_d = S_IDLE;
            endcase
        end else begin
            unit_cnt_d = tick ? 16'd0 : unit_cnt_q + 16'd1;
            if (tick) mult_d = mult_q + 2'd1;
        end

        // Outputs are registered copies of the next-state decode, so they line up with state_q.
        key_out_d    = (state_d == S_MARK);
        busy_d       = (state_d != S_IDLE);
        char_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            unit_cnt_q   <= 16'd0;
            mult_q       <= 2'd0;
            elem_idx_q   <= 3'd0;
            len_q        <= 3'd0;
            pat_q        <= 5'd0;
            key_out_q    <= 1'b0;
            busy_q       <= 1'b0;
            char_ready_q <= 1'b1;
            bad_char_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            unit_cnt_q   <= unit_cnt_d;
            mult_q       <= mult_d;
            elem_idx_q   <= elem_idx_d;
            len_q        <= len_d;
            pat_q        <= pat_d;
            key_out_q    <= key_out_d;
            busy_q       <= busy_d;
            char_ready_q <= char_ready_d;
            bad_char_q   <= bad_char_d;
        end
    end

    assign bus.key_out    = key_out_q;
    assign bus.busy       = busy_q;
    assign bus.char_ready = char_ready_q;
    assign bus.bad_char   = bad_char_q;
    assign bus.dbg_state  = state_q;
endmodule
